// File: rtl/clause_literal_feeder.sv
// Fetches a clause from the clause table, strips the literal of the variable being
// flipped, feeds the rest to an external evaluator and returns its break verdict.
module clause_literal_feeder #(
  parameter int NSAT         = 3,
  parameter int NUM_VARS     = 64,
  parameter int VAR_IDX_W    = 6,
  parameter int CLAUSE_IDX_W = 8,
  parameter int EVAL_LATENCY = 2
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              req_valid_i,
  output logic                              req_ready_o,
  input  logic [CLAUSE_IDX_W-1:0]           req_clause_i,
  input  logic [VAR_IDX_W-1:0]              req_excl_var_i,
  input  logic [NUM_VARS-1:0]               assign_i,
  output logic                              ct_en_o,
  output logic [CLAUSE_IDX_W-1:0]           ct_addr_o,
  input  logic [NSAT*(VAR_IDX_W+1)-1:0]     ct_rdata_i,
  output logic [NSAT-2:0]                   var_val_o,
  output logic [NSAT-2:0]                   var_neg_o,
  input  logic                              break_i,
  output logic                              resp_valid_o,
  input  logic                              resp_ready_i,
  output logic                              resp_break_o,
  output logic                              resp_err_o,
  output logic [CLAUSE_IDX_W-1:0]           resp_clause_o
);

  localparam int LIT_W  = VAR_IDX_W + 1;
  localparam int CNT_W  = $clog2(EVAL_LATENCY + 2);
  localparam int SLOT_W = (NSAT > 1) ? $clog2(NSAT) : 1;

  typedef enum logic [2:0] {IDLE, RD, WAIT, EVAL, RESP} state_t;

  state_t                       state, state_nxt;
  logic [CLAUSE_IDX_W-1:0]      clause_q;
  logic [VAR_IDX_W-1:0]         excl_q;
  logic [CNT_W-1:0]             cnt;
  logic [NSAT-1:0][LIT_W-1:0]   lits;
  logic                         matched;
  logic                         bad_idx;
  logic [SLOT_W-1:0]            match_slot;
  logic                         wait_err;
  logic                         eval_done;
  logic [NSAT-2:0]              val_nxt;
  logic [NSAT-2:0]              neg_nxt;

  assign lits          = ct_rdata_i;
  assign eval_done     = (state == EVAL) && (cnt == CNT_W'(EVAL_LATENCY));
  assign req_ready_o   = (state == IDLE);
  assign ct_en_o       = (state == RD);
  assign ct_addr_o     = clause_q;
  assign resp_clause_o = clause_q;

  // Only the first slot matching the flipped variable is dropped; the survivors
  // pack down in ascending slot order.
  always_comb begin
    matched    = 1'b0;
    bad_idx    = 1'b0;
    match_slot = '0;
    val_nxt    = var_val_o;
    neg_nxt    = var_neg_o;
    for (int k = 0; k < NSAT; k++) begin
      if (int'(lits[k][VAR_IDX_W-1:0]) >= NUM_VARS) bad_idx = 1'b1;
      if (!matched && (lits[k][VAR_IDX_W-1:0] == excl_q)) begin
        matched    = 1'b1;
        match_slot = SLOT_W'(k);
      end
    end
    for (int j = 0; j < NSAT - 1; j++) begin
      for (int k = 0; k < NSAT; k++) begin
        if (((k == j) && (j < int'(match_slot))) ||
            ((k == j + 1) && (j >= int'(match_slot)))) begin
          val_nxt[j] = assign_i[lits[k][VAR_IDX_W-1:0]];
          neg_nxt[j] = lits[k][VAR_IDX_W];
        end
      end
    end
    wait_err = bad_idx | ~matched;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req_valid_i) state_nxt = RD;
      RD:      state_nxt = WAIT;
      WAIT:    state_nxt = wait_err ? RESP : EVAL;
      EVAL:    if (eval_done) state_nxt = RESP;
      RESP:    if (resp_valid_o && resp_ready_i) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // On the error path RESP is entered with resp_valid_o low and raised one edge
  // later; on the normal path it rises together with the break capture.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      clause_q     <= '0;
      excl_q       <= '0;
      cnt          <= '0;
      var_val_o    <= '1;
      var_neg_o    <= '0;
      resp_break_o <= 1'b0;
      resp_err_o   <= 1'b0;
      resp_valid_o <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (req_valid_i) begin
            clause_q <= req_clause_i;
            excl_q   <= req_excl_var_i;
          end
        end
        WAIT: begin
          if (wait_err) begin
            resp_err_o   <= 1'b1;
            resp_break_o <= 1'b0;
          end else begin
            var_val_o <= val_nxt;
            var_neg_o <= neg_nxt;
          end
        end
        EVAL: begin
          if (eval_done) begin
            cnt          <= '0;
            resp_break_o <= break_i;
            resp_err_o   <= 1'b0;
            resp_valid_o <= 1'b1;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        RESP: begin
          if (!resp_valid_o)     resp_valid_o <= 1'b1;
          else if (resp_ready_i) resp_valid_o <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_clause_literal_feeder.sv
// Randomised scoreboard bench for clause_literal_feeder with a clause-table memory
// and a two-cycle clause evaluator model.
module tb_clause_literal_feeder;

  localparam int NSAT = 3;
  localparam int NV   = 8;
  localparam int VW   = 3;
  localparam int CW   = 8;
  localparam int LAT  = 2;
  localparam int LW   = VW + 1;

  logic                 clk = 1'b0;
  logic                 rst_ni = 1'b0;
  logic                 req_valid_i = 1'b0;
  logic                 req_ready_o;
  logic [CW-1:0]        req_clause_i = '0;
  logic [VW-1:0]        req_excl_var_i = '0;
  logic [NV-1:0]        assign_i = '0;
  logic                 ct_en_o;
  logic [CW-1:0]        ct_addr_o;
  logic [NSAT*LW-1:0]   ct_rdata_i = '0;
  logic [NSAT-2:0]      var_val_o;
  logic [NSAT-2:0]      var_neg_o;
  logic                 break_i;
  logic                 resp_valid_o;
  logic                 resp_ready_i = 1'b0;
  logic                 resp_break_o;
  logic                 resp_err_o;
  logic [CW-1:0]        resp_clause_o;

  always #5 clk = ~clk;

  clause_literal_feeder #(
    .NSAT(NSAT), .NUM_VARS(NV), .VAR_IDX_W(VW), .CLAUSE_IDX_W(CW), .EVAL_LATENCY(LAT)
  ) dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_clause_i(req_clause_i), .req_excl_var_i(req_excl_var_i), .assign_i(assign_i),
    .ct_en_o(ct_en_o), .ct_addr_o(ct_addr_o), .ct_rdata_i(ct_rdata_i),
    .var_val_o(var_val_o), .var_neg_o(var_neg_o), .break_i(break_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .resp_break_o(resp_break_o), .resp_err_o(resp_err_o), .resp_clause_o(resp_clause_o)
  );

  // Clause table and clause evaluator environment
  logic [NSAT*LW-1:0] ct_mem [0:255];
  always @(posedge clk) if (ct_en_o) ct_rdata_i <= ct_mem[ct_addr_o];

  logic b1, b2;
  always @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      b1 <= 1'b0;
      b2 <= 1'b0;
    end else begin
      b1 <= ~|(var_val_o ^ var_neg_o);
      b2 <= b1;
    end
  end
  assign break_i = b2;

  typedef struct {
    logic            brk;
    logic            err;
    logic [CW-1:0]   clause;
    logic [NSAT-2:0] vv;
    logic [NSAT-2:0] vn;
    int              lat;
    time             acc;
  } exp_t;

  exp_t            sb_q[$];
  logic [NSAT-2:0] model_vv = '1;
  logic [NSAT-2:0] model_vn = '0;
  int              n_cmp = 0;
  int              n_fail = 0;
  int              bp_left = 0;

  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: drop the first literal on the flipped variable; the clause breaks
  // when every remaining literal is false under the current assignment.
  task automatic push_expected(input logic [CW-1:0] c, input logic [VW-1:0] ex,
                               input logic [NV-1:0] a, input time t);
    exp_t e;
    logic [NSAT-1:0][LW-1:0] lits;
    int first;
    lits     = ct_mem[c];
    first    = -1;
    e.clause = c;
    e.acc    = t;
    e.vv     = model_vv;
    e.vn     = model_vn;
    for (int k = 0; k < NSAT; k++)
      if (first < 0 && lits[k][VW-1:0] == ex) first = k;
    if (first < 0) begin
      e.err = 1'b1;
      e.brk = 1'b0;
      e.lat = 3;
    end else begin
      e.err = 1'b0;
      e.brk = 1'b1;
      e.lat = LAT + 3;
      for (int k = 0; k < NSAT; k++) begin
        if (k != first) begin
          e.vv = {a[lits[k][VW-1:0]], e.vv[NSAT-2:1]};
          e.vn = {lits[k][VW], e.vn[NSAT-2:1]};
          if (a[lits[k][VW-1:0]] ^ lits[k][VW]) e.brk = 1'b0;
        end
      end
      model_vv = e.vv;
      model_vn = e.vn;
    end
    sb_q.push_back(e);
  endtask

  task automatic send(input logic [CW-1:0] c, input logic [VW-1:0] ex, input logic [NV-1:0] a);
    int n = 0;
    @(negedge clk);
    while (!req_ready_o && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("req_ready_timeout", int'(req_ready_o), 1);
    if (req_ready_o) begin
      req_valid_i    = 1'b1;
      req_clause_i   = c;
      req_excl_var_i = ex;
      assign_i       = a;
      @(posedge clk);
      push_expected(c, ex, a, $time);
      #1 req_valid_i = 1'b0;
    end
  endtask

  // Consumer ready: forced low for bp_left cycles of a presented response
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (bp_left > 0) begin
        resp_ready_i = 1'b0;
        if (resp_valid_o) bp_left--;
      end else begin
        resp_ready_i = ($urandom_range(0, 3) != 0);
      end
    end
  end

  // Monitor
  initial begin
    exp_t cur;
    bit   active = 0;
    bit   prev = 0;
    bit   hs = 0;
    forever begin
      @(negedge clk);
      if (!rst_ni) begin
        active = 0;
        prev   = 0;
        hs     = 0;
        continue;
      end
      if (hs) begin
        check("idle_after_accept_ready", int'(req_ready_o), 1);
        check("idle_after_accept_valid", int'(resp_valid_o), 0);
      end
      if (ct_en_o) begin
        check("ct_en_has_request", int'(sb_q.size() > 0), 1);
        if (sb_q.size() > 0) check("ct_addr", int'(ct_addr_o), int'(sb_q[0].clause));
      end
      if (resp_valid_o) begin
        if (!prev) begin
          check("resp_expected", int'(sb_q.size() > 0), 1);
          if (sb_q.size() > 0) begin
            cur    = sb_q.pop_front();
            active = 1;
            check("latency", int'(($time - 5 - cur.acc) / 10), cur.lat);
          end
        end
        if (active) begin
          check("resp_break", int'(resp_break_o), int'(cur.brk));
          check("resp_err", int'(resp_err_o), int'(cur.err));
          check("resp_clause", int'(resp_clause_o), int'(cur.clause));
          check("var_val", int'(var_val_o), int'(cur.vv));
          check("var_neg", int'(var_neg_o), int'(cur.vn));
          check("req_ready_busy", int'(req_ready_o), 0);
        end
      end
      hs   = resp_valid_o && resp_ready_i;
      if (hs) active = 0;
      prev = resp_valid_o;
    end
  end

  initial begin
    logic [NSAT-1:0][LW-1:0] lits;
    logic [1:0]              ks;
    logic [CW-1:0]           c;
    logic [VW-1:0]           ex;
    int                      n;
    for (int i = 0; i < 256; i++) ct_mem[i] = (NSAT*LW)'($urandom);
    ct_mem[10] = 12'h7D2;  // x2, ~x5, x7
    ct_mem[11] = 12'h1C4;  // x4, ~x4, x1

    repeat (2) @(negedge clk);
    check("rst_resp_valid", int'(resp_valid_o), 0);
    check("rst_ct_en", int'(ct_en_o), 0);
    check("rst_resp_break", int'(resp_break_o), 0);
    check("rst_resp_err", int'(resp_err_o), 0);
    check("rst_var_val", int'(var_val_o), 3);
    check("rst_var_neg", int'(var_neg_o), 0);
    check("rst_resp_clause", int'(resp_clause_o), 0);
    @(posedge clk);
    #2 rst_ni = 1'b1;
    @(negedge clk);
    check("ready_after_reset", int'(req_ready_o), 1);

    bp_left = 4;
    send(8'd10, 3'd2, 8'b0010_0000);   // break with back-pressure
    send(8'd10, 3'd2, 8'b1010_0000);   // no break
    send(8'd10, 3'd3, 8'($urandom));   // error: excl absent
    send(8'd11, 3'd4, 8'($urandom));   // duplicate literal

    // Reset while in EVAL
    send(8'd10, 3'd2, 8'b0010_0000);
    @(posedge clk);
    @(posedge clk);
    #3 rst_ni = 1'b0;
    sb_q.delete();
    model_vv = '1;
    model_vn = '0;
    #1;
    check("midrst_resp_valid", int'(resp_valid_o), 0);
    check("midrst_ct_en", int'(ct_en_o), 0);
    check("midrst_resp_break", int'(resp_break_o), 0);
    check("midrst_resp_err", int'(resp_err_o), 0);
    check("midrst_var_val", int'(var_val_o), 3);
    check("midrst_var_neg", int'(var_neg_o), 0);
    check("midrst_resp_clause", int'(resp_clause_o), 0);
    check("midrst_ready", int'(req_ready_o), 1);
    repeat (2) @(posedge clk);
    #2 rst_ni = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", int'(req_ready_o), 1);
    send(8'd10, 3'd2, 8'b0010_0000);

    for (int t = 0; t < 60; t++) begin
      c    = CW'($urandom_range(0, 255));
      lits = ct_mem[c];
      ks   = 2'($urandom_range(0, 3));
      if (ks == 2'd3) ex = VW'($urandom);
      else            ex = lits[ks][VW-1:0];
      if (t % 15 == 7) bp_left = $urandom_range(1, 5);
      send(c, ex, NV'($urandom));
    end

    n = 0;
    @(negedge clk);
    while ((sb_q.size() != 0 || resp_valid_o) && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", int'(sb_q.size() == 0 && !resp_valid_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/clause_literal_feeder.md
CLAUSE_LITERAL_FEEDER -- requirements
Module: clause_literal_feeder

Interface
REQ-001 Parameters SHALL be, one per line:
  NSAT, 3, literals per clause.
  NUM_VARS, 64, number of variables.
  VAR_IDX_W, 6, literal variable-index width.
  CLAUSE_IDX_W, 8, clause-table address width.
  EVAL_LATENCY, 2, clock edges from var_val_o/var_neg_o change to a valid break_i.
REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
  clk_i  in  1  single clock; all state updates on the rising edge.
  rst_ni  in  1  reset, asynchronous, active-low.
  req_valid_i  in  1  evaluation request valid.
  req_ready_o  out  1  feeder can accept a request.
  req_clause_i  in  CLAUSE_IDX_W  clause to evaluate.
  req_excl_var_i  in  VAR_IDX_W  variable being flipped; its literal is excluded.
  assign_i  in  NUM_VARS  current variable assignment, bit v = value of variable v.
  ct_en_o  out  1  clause-table read enable.
  ct_addr_o  out  CLAUSE_IDX_W  clause-table address.
  ct_rdata_i  in  NSAT*(VAR_IDX_W+1)  clause literals, valid the cycle after ct_en_o.
  var_val_o  out  NSAT-1  literal variable values to the clause evaluator.
  var_neg_o  out  NSAT-1  literal negation bits to the clause evaluator.
  break_i  in  1  break result from the clause evaluator.
  resp_valid_o  out  1  response valid.
  resp_ready_i  in  1  consumer accepts the response.
  resp_break_o  out  1  clause breaks if req_excl_var_i is flipped.
  resp_err_o  out  1  malformed clause or request.
  resp_clause_o  out  CLAUSE_IDX_W  echo of req_clause_i.

Function
REQ-003 Literal slot k SHALL be ct_rdata_i[k*(VAR_IDX_W+1) +: VAR_IDX_W+1]; the MSB is the negation bit and the low VAR_IDX_W bits are the variable index.
REQ-004 FSM states SHALL be IDLE, RD, WAIT, EVAL and RESP; req_ready_o SHALL be 1 only in IDLE.
REQ-005 IDLE: on req_valid_i&&req_ready_o, the feeder SHALL latch req_clause_i and req_excl_var_i and go to RD.
REQ-006 RD: ct_en_o SHALL be 1 and ct_addr_o SHALL equal the latched clause for exactly one cycle, then go to WAIT; ct_en_o SHALL be 0 in all other states.
REQ-007 WAIT: the feeder SHALL sample ct_rdata_i and exclude the lowest-numbered slot whose index equals the latched excl var.
REQ-008 WAIT: the remaining NSAT-1 slots, in ascending slot order, SHALL load var_neg_o[j] with the slot negation bit and var_val_o[j] with assign_i[index]; then go to EVAL.
REQ-009 WAIT error: if no slot matches the excl var, or any slot index is >= NUM_VARS, the feeder SHALL go directly to RESP with resp_err_o=1 and resp_break_o=0, leaving var_val_o and var_neg_o unchanged.
REQ-010 EVAL: a counter SHALL hold for EVAL_LATENCY+1 cycles; on the final edge, break_i SHALL be captured into resp_break_o with resp_err_o=0, then go to RESP.
REQ-011 Timing: resp_valid_o SHALL rise EVAL_LATENCY+3 edges after the accepting edge on the normal path, and 3 edges after it on the error path.
REQ-012 RESP: resp_valid_o=1, and resp_break_o, resp_err_o and resp_clause_o SHALL be held stable until resp_valid_o&&resp_ready_i; then go to IDLE.
REQ-013 Back-to-back: no new request SHALL be accepted on the cycle a response is accepted; the earliest next accept is the following cycle.
REQ-014 Duplicates: when a duplicate literal of the excl var exists, only the first SHALL be excluded and the second SHALL be evaluated normally.
REQ-015 var_val_o and var_neg_o SHALL be registered and SHALL hold their value outside WAIT loads.

Reset
REQ-016 While rst_ni=0, the FSM SHALL be asynchronously forced to IDLE.
REQ-017 While rst_ni=0, resp_valid_o, ct_en_o, resp_break_o, resp_err_o, var_neg_o, resp_clause_o and the counter SHALL be 0, and var_val_o SHALL be all ones, so any downstream break evaluates to 0.
REQ-018 A reset asserted mid-operation SHALL abandon the request with no response produced; req_ready_o SHALL be 1 in the first cycle after rst_ni rises.

Verification (NSAT=3, NUM_VARS=8, VAR_IDX_W=3, EVAL_LATENCY=2, behavioural evaluator model)
REQ-019 Break case: clause={x2 pos, x5 neg, x7 pos}, excl=2, x5=1, x7=0 -> resp_break_o=1, resp_err_o=0, resp_valid_o exactly 5 edges after accept.
REQ-020 No-break case: same clause, x7=1 -> resp_break_o=0, var_val_o=2'b11, var_neg_o=2'b01.
REQ-021 Error case: excl=3 not present -> resp_err_o=1, resp_break_o=0, resp_valid_o 3 edges after accept, no var_* change.
REQ-022 Back-pressure: resp_ready_i=0 for 4 cycles -> response fields stable, req_ready_o=0 throughout; accept on ready, then IDLE.
REQ-023 Reset case: rst_ni pulsed low during EVAL -> outputs at reset values immediately, no resp_valid_o, new request accepted normally.
REQ-024 Duplicate case: clause={x4 pos, x4 neg, x1 pos}, excl=4 -> slots 1 and 2 evaluated, var_neg_o=2'b01.
